// File: rtl/pic_pkg.sv
// Shared types and helpers for the PIC priority resolver: sizes, FSM states and
// the rotating priority search used for both the request and in-service vectors.
package pic_pkg;

   localparam int NIRQ = 8;
   localparam int LVLW = 3;

   typedef enum logic [1:0] {
      IDLE,
      ACK1,
      ACK2
   } fsm_e;

   typedef struct packed {
      logic            found;
      logic [LVLW-1:0] lvl;
   } prio_t;

   // Highest-priority set bit when lp is the lowest-priority level. Scanning from
   // lowest to highest lets the last hit be the winner.
   function automatic prio_t rot_prio(input logic [NIRQ-1:0] vec,
                                      input logic [LVLW-1:0] lp);
      prio_t           res;
      logic [LVLW-1:0] idx;
      res = '0;
      for (int k = NIRQ; k >= 1; k--) begin
         idx = lp + LVLW'(k);
         if (vec[idx]) begin
            res.found = 1'b1;
            res.lvl   = idx;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/pic_prio_find.sv
// Combinational rotating priority encoder: winning level plus its rank, where
// rank 0 is the highest priority under the current lowest-priority pointer.
module pic_prio_find
   import pic_pkg::*;
(
   input  logic [NIRQ-1:0] vec_i,
   input  logic [LVLW-1:0] lp_i,
   output logic            found_o,
   output logic [LVLW-1:0] lvl_o,
   output logic [LVLW-1:0] rank_o
);

   prio_t res;

   always_comb begin
      res     = rot_prio(vec_i, lp_i);
      found_o = res.found;
      lvl_o   = res.lvl;
      rank_o  = res.lvl - lp_i - LVLW'(1);
   end

endmodule

// File: rtl/pic_prio_resolver.sv
// IRR/ISR registers, rotating priority resolution under mask, INT generation and
// the two-pulse INTA acknowledge sequence of an 8259-style interrupt controller.
module pic_prio_resolver
   import pic_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic [NIRQ-1:0] ir,
   input  logic            ltim,
   input  logic [NIRQ-1:0] mask,
   input  logic            aeoi,
   input  logic            eoi,
   input  logic            eoi_spec,
   input  logic [LVLW-1:0] eoi_lvl,
   input  logic            rot,
   input  logic            inta_n,
   output logic            int_o,
   output logic [NIRQ-1:0] irr,
   output logic [NIRQ-1:0] isr,
   output logic [LVLW-1:0] vec_lvl,
   output logic            vec_vld,
   output logic            cl_sig
);

   fsm_e            state_q;
   logic [NIRQ-1:0] ir_q, irr_q, irr_d, isr_q, isr_d;
   logic [LVLW-1:0] lp_q, lp_d, lvl_q, vec_lvl_q, eoi_sel;
   logic            inta_q, spur_q, int_q, int_d, vec_vld_q, cl_q;
   logic            inta_fall, inta_rise, ack1_evt, done_evt;
   logic            cand_found, top_found;
   logic [LVLW-1:0] cand_lvl, cand_rank, top_lvl, top_rank;

   pic_prio_find u_cand (
      .vec_i   (irr_q & ~mask),
      .lp_i    (lp_q),
      .found_o (cand_found),
      .lvl_o   (cand_lvl),
      .rank_o  (cand_rank)
   );

   pic_prio_find u_top (
      .vec_i   (isr_q),
      .lp_i    (lp_q),
      .found_o (top_found),
      .lvl_o   (top_lvl),
      .rank_o  (top_rank)
   );

   assign inta_fall = inta_q & ~inta_n;
   assign inta_rise = ~inta_q & inta_n;
   assign ack1_evt  = (state_q == IDLE) && inta_fall;
   assign done_evt  = (state_q == ACK2) && inta_rise;
   assign eoi_sel   = eoi_spec ? eoi_lvl : top_lvl;

   // NOTE: every variable gets a default at the top of always_comb so no path
   // leaves one unassigned, which would otherwise infer a latch.
   always_comb begin
      irr_d = ltim ? ir : ((irr_q | (ir & ~ir_q)) & ir);
      isr_d = isr_q;
      lp_d  = lp_q;
      if (ack1_evt && cand_found && !ltim) begin
         irr_d[cand_lvl] = 1'b0;
      end
      // EOI acts on the old ISR; an ACK1 set in the same cycle is applied last.
      if (eoi && (isr_q != '0)) begin
         isr_d[eoi_sel] = 1'b0;
         if (rot) lp_d = eoi_sel;
      end
      if (done_evt && aeoi && !spur_q) begin
         isr_d[lvl_q] = 1'b0;
         if (rot) lp_d = lvl_q;
      end
      if (ack1_evt && cand_found) begin
         isr_d[cand_lvl] = 1'b1;
      end
      // Fully nested: only a strictly higher-ranked request interrupts service.
      int_d = !ack1_evt && cand_found &&
              (!top_found || (cand_rank < top_rank));
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         ir_q      <= '0;
         inta_q    <= 1'b1;
         irr_q     <= '0;
         isr_q     <= '0;
         lp_q      <= LVLW'(NIRQ - 1);
         lvl_q     <= '0;
         spur_q    <= 1'b0;
         int_q     <= 1'b0;
         vec_lvl_q <= '0;
         vec_vld_q <= 1'b0;
         cl_q      <= 1'b0;
      end else begin
         ir_q   <= ir;
         inta_q <= inta_n;
         irr_q  <= irr_d;
         isr_q  <= isr_d;
         lp_q   <= lp_d;
         int_q  <= int_d;
         cl_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (inta_fall) begin
                  state_q <= ACK1;
                  lvl_q   <= cand_found ? cand_lvl : LVLW'(NIRQ - 1);
                  spur_q  <= !cand_found;
               end
            end
            ACK1: begin
               if (inta_fall) begin
                  state_q   <= ACK2;
                  vec_lvl_q <= lvl_q;
                  vec_vld_q <= 1'b1;
                  cl_q      <= 1'b1;
               end
            end
            ACK2: begin
               if (inta_rise) begin
                  state_q   <= IDLE;
                  vec_vld_q <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign int_o   = int_q;
   assign irr     = irr_q;
   assign isr     = isr_q;
   assign vec_lvl = vec_lvl_q;
   assign vec_vld = vec_vld_q;
   assign cl_sig  = cl_q;

endmodule

// File: tb/tb_pic_prio_resolver.sv
// Self-checking bench for pic_prio_resolver: directed scenarios plus random
// stimulus compared every cycle against a behavioural model of the PIC rules.
module tb_pic_prio_resolver;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] ir, mask, irr, isr;
   logic       ltim, aeoi, eoi, eoi_spec, rot, inta_n;
   logic [2:0] eoi_lvl, vec_lvl;
   logic       int_o, vec_vld, cl_sig;

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model state.
   logic [7:0] m_irr, m_isr, m_ir_prev;
   int         m_lp, m_phase, m_lvl, m_vec_lvl;
   bit         m_spur, m_int, m_vld, m_cl, m_inta_prev;

   pic_prio_resolver dut (
      .clk      (clk),
      .rst      (rst),
      .ir       (ir),
      .ltim     (ltim),
      .mask     (mask),
      .aeoi     (aeoi),
      .eoi      (eoi),
      .eoi_spec (eoi_spec),
      .eoi_lvl  (eoi_lvl),
      .rot      (rot),
      .inta_n   (inta_n),
      .int_o    (int_o),
      .irr      (irr),
      .isr      (isr),
      .vec_lvl  (vec_lvl),
      .vec_vld  (vec_vld),
      .cl_sig   (cl_sig)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, summary not reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Level of the highest-priority set bit, or -1; priority runs lp+1 .. lp mod 8.
   function automatic int best(input logic [7:0] v, input int lp);
      for (int r = 0; r < 8; r++) begin
         if (v[(lp + 1 + r) % 8]) return (lp + 1 + r) % 8;
      end
      return -1;
   endfunction

   function automatic int rank(input int lvl, input int lp);
      return (lvl - lp - 1 + 16) % 8;
   endfunction

   task automatic model_reset();
      m_irr = '0; m_isr = '0; m_ir_prev = '0;
      m_lp = 7; m_phase = 0; m_lvl = 0; m_vec_lvl = 0;
      m_spur = 0; m_int = 0; m_vld = 0; m_cl = 0; m_inta_prev = 1;
   endtask

   // One clock edge of the specification's rules, from the pre-edge state.
   task automatic model_step();
      int         c, t, e, nlp;
      bit         fall, rise, nint;
      logic [7:0] nirr, nisr;
      if (rst) begin
         model_reset();
         return;
      end
      c    = best(m_irr & ~mask, m_lp);
      t    = best(m_isr, m_lp);
      fall = m_inta_prev && !inta_n;
      rise = !m_inta_prev && inta_n;
      nirr = ltim ? ir : ((m_irr | (ir & ~m_ir_prev)) & ir);
      nisr = m_isr;
      nlp  = m_lp;
      nint = (c >= 0) && (m_isr == 0 || rank(c, m_lp) < rank(t, m_lp));
      m_cl = 0;
      if (eoi && m_isr != 0) begin
         e = eoi_spec ? int'(eoi_lvl) : t;
         nisr[e] = 1'b0;
         if (rot) nlp = e;
      end
      if (m_phase == 0 && fall) begin
         m_spur = (c < 0);
         m_lvl  = m_spur ? 7 : c;
         if (!m_spur) begin
            nisr[c] = 1'b1;
            if (!ltim) nirr[c] = 1'b0;
         end
         nint = 0;
         m_phase = 1;
      end else if (m_phase == 1 && fall) begin
         m_vec_lvl = m_lvl;
         m_vld = 1;
         m_cl = 1;
         m_phase = 2;
      end else if (m_phase == 2 && rise) begin
         m_vld = 0;
         if (aeoi && !m_spur) begin
            nisr[m_lvl] = 1'b0;
            if (rot) nlp = m_lvl;
         end
         m_phase = 0;
      end
      m_irr = nirr; m_isr = nisr; m_lp = nlp; m_int = nint;
      m_ir_prev = ir; m_inta_prev = inta_n;
   endtask

   task automatic compare_all();
      check("irr", irr, m_irr);
      check("isr", isr, m_isr);
      check("int_o", int_o, m_int);
      check("vec_vld", vec_vld, m_vld);
      check("cl_sig", cl_sig, m_cl);
      check("vec_lvl", vec_lvl, m_vec_lvl[2:0]);
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic ack_first();
      inta_n = 1'b0; cyc();
      inta_n = 1'b1; cyc();
      inta_n = 1'b0; cyc();
   endtask

   task automatic ack_finish();
      inta_n = 1'b1; cyc();
   endtask

   initial begin
      rst = 1'b1; ir = '0; mask = '0; ltim = 0; aeoi = 0; eoi = 0;
      eoi_spec = 0; eoi_lvl = '0; rot = 0; inta_n = 1'b1;
      model_reset();
      #1;
      repeat (2) cyc();
      rst = 1'b0;
      check("reset_irr", irr, 8'h00);
      check("reset_isr", isr, 8'h00);
      check("reset_int", int_o, 1'b0);
      check("reset_vld", vec_vld, 1'b0);

      // T1: basic edge-triggered request and acknowledge.
      ir = 8'h08; cyc(); cyc();
      check("t1_int", int_o, 1'b1);
      ack_first();
      check("t1_vec_lvl", vec_lvl, 3'd3);
      check("t1_cl_sig", cl_sig, 1'b1);
      check("t1_vld", vec_vld, 1'b1);
      ack_finish();
      check("t1_isr", isr, 8'h08);
      check("t1_irr", irr, 8'h00);
      check("t1_cl_off", cl_sig, 1'b0);

      // T2: lower priority blocked, higher priority nests.
      ir = 8'h28; cyc(); cyc();
      check("t2_no_int", int_o, 1'b0);
      ir = 8'h2a; cyc(); cyc();
      check("t2_int", int_o, 1'b1);
      ack_first();
      check("t2_vec_lvl", vec_lvl, 3'd1);
      ack_finish();
      check("t2_isr", isr, 8'h0a);
      ir = '0; eoi = 1; cyc(); cyc(); eoi = 0;
      check("t2_eoi_isr", isr, 8'h00);

      // T3: rotation on non-specific EOI.
      rot = 1; ir = 8'h04; cyc(); cyc();
      ack_first(); ack_finish();
      eoi = 1; cyc(); eoi = 0;
      check("t3_isr", isr, 8'h00);
      ir = '0; cyc();
      ir = 8'h14; cyc(); cyc();
      ack_first();
      check("t3_vec_lvl", vec_lvl, 3'd4);
      ack_finish();
      ir = '0; eoi = 1; cyc(); eoi = 0; rot = 0; cyc();

      // T4: automatic EOI.
      aeoi = 1; ir = 8'h40; cyc(); cyc();
      ack_first();
      check("t4_isr_ack2", isr, 8'h40);
      ack_finish();
      check("t4_isr_done", isr, 8'h00);
      aeoi = 0; ir = '0; cyc();

      // T5: spurious acknowledge, then level mode keeps IRR.
      ir = 8'h01; cyc(); ir = '0; cyc();
      ack_first();
      check("t5_spur_lvl", vec_lvl, 3'd7);
      check("t5_spur_isr", isr, 8'h00);
      ack_finish();
      ltim = 1; ir = 8'h10; cyc(); cyc();
      ack_first();
      check("t5_lvl_irr", irr, 8'h10);
      ack_finish();
      check("t5_lvl_isr", isr, 8'h10);
      ir = '0; eoi = 1; eoi_spec = 1; eoi_lvl = 3'd4; cyc();
      eoi = 0; eoi_spec = 0; ltim = 0; cyc();
      check("t5_spec_eoi", isr, 8'h00);

      // EOI in the same cycle as ACK1 on the same level: bit ends set.
      ir = 8'h08; cyc(); cyc();
      ack_first(); ack_finish();
      ir = '0; cyc(); ir = 8'h08; cyc(); cyc();
      check("same_lvl_no_int", int_o, 1'b0);
      inta_n = 1'b0; eoi = 1; cyc(); eoi = 0;
      check("eoi_ack1_isr", isr, 8'h08);
      check("eoi_ack1_irr", irr, 8'h00);
      inta_n = 1'b1; cyc(); inta_n = 1'b0; cyc();
      check("eoi_ack1_vec", vec_lvl, 3'd3);
      ack_finish();
      ir = '0; eoi = 1; cyc(); eoi = 0; cyc();

      // T6: reset in the middle of the sequence.
      ir = 8'h08; cyc(); cyc();
      inta_n = 1'b0; cyc();
      rst = 1'b1; model_reset(); #1;
      check("t6_irr", irr, 8'h00);
      check("t6_isr", isr, 8'h00);
      check("t6_int", int_o, 1'b0);
      check("t6_vld", vec_vld, 1'b0);
      check("t6_vec_lvl", vec_lvl, 3'd0);
      inta_n = 1'b1; ir = '0; cyc(); cyc();
      rst = 1'b0;
      ir = 8'h81; cyc(); cyc();
      ack_first();
      check("t6_lp7_vec", vec_lvl, 3'd0);
      ack_finish();
      check("t6_isr_after", isr, 8'h01);
      ir = '0; eoi = 1; cyc(); eoi = 0; cyc();

      // Random phase against the model.
      for (int n = 0; n < 2000; n++) begin
         if ($urandom_range(0, 3) == 0) ir = ir ^ (8'h01 << $urandom_range(0, 7));
         if ($urandom_range(0, 49) == 0) mask = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
         if ($urandom_range(0, 99) == 0) begin
            aeoi = 1'($urandom_range(0, 1));
            rot  = 1'($urandom_range(0, 1));
         end
         if (n % 500 == 499) ltim = ~ltim;
         if ($urandom_range(0, 3) == 0) inta_n = ~inta_n;
         eoi = 0;
         if (!(!m_inta_prev && inta_n) && $urandom_range(0, 7) == 0) begin
            eoi      = 1;
            eoi_spec = 1'($urandom_range(0, 1));
            eoi_lvl  = 3'($urandom_range(0, 7));
         end
         cyc();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
